// File: rtl/dmem_ctrl.sv
// dmem_ctrl: multi-cycle, word-addressed data-memory controller.
// Holds the datapath through a stall while one load/store completes after a
// configurable number of wait cycles. Requests with addr[0]=1 raise a sticky
// error flag and are not performed.
module dmem_ctrl #(
    parameter int n       = 16,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         memread,
    input  logic         memwrite,
    input  logic [n-1:0] addr,
    input  logic [n-1:0] writedata,
    output logic [n-1:0] readdata,
    output logic         stall,
    output logic         misalign_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_nxt_s;
    logic [CW-1:0]  cnt_r;
    logic           op_wr_r;
    logic [AW-1:0]  idx_r;
    logic [n-1:0]   wdata_r;
    logic [n-1:0]   readdata_r;
    logic           misalign_r;
    logic [n-1:0]   mem_r [DEPTH];

    logic           req_s;
    logic           start_s;
    logic           access_s;
    logic           misalign_s;
    logic           stall_s;

    // Upper address bits are intentionally ignored, so addresses alias.
    logic           unused_addr_s;
    assign unused_addr_s = ^addr[n-1:AW+1];

    assign req_s        = memread | memwrite;
    assign readdata     = readdata_r;
    assign stall        = stall_s;
    assign misalign_err = misalign_r;

    // Next-state and stall decode; requests are only looked at in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        stall_s     = 1'b0;
        start_s     = 1'b0;
        access_s    = 1'b0;
        misalign_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    if (addr[0]) begin
                        misalign_s = 1'b1;
                    end else begin
                        stall_s     = 1'b1;
                        start_s     = 1'b1;
                        state_nxt_s = WAIT;
                    end
                end else begin
                    stall_s = 1'b0;
                end
            end
            WAIT: begin
                stall_s = 1'b1;
                if (cnt_r == CNT_ZERO) begin
                    access_s    = 1'b1;
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            DONE: begin
                // Datapath retires here; held request lines must not re-fire.
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Control state, latched request, read result and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= CNT_ZERO;
            op_wr_r    <= 1'b0;
            idx_r      <= {AW{1'b0}};
            wdata_r    <= {n{1'b0}};
            readdata_r <= {n{1'b0}};
            misalign_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (start_s) begin
                op_wr_r <= memwrite;          // both high counts as a write
                idx_r   <= addr[AW:1];
                wdata_r <= writedata;
                cnt_r   <= CNT_INIT;
            end else if ((state_r == WAIT) && (cnt_r != CNT_ZERO)) begin
                cnt_r <= cnt_r - CNT_ONE;
            end
            if (access_s && !op_wr_r) begin
                readdata_r <= mem_r[idx_r];
            end
            if (misalign_s) begin
                misalign_r <= 1'b1;
            end
        end
    end

    // Storage write port; never cleared, and a reset edge drops a pending store.
    always_ff @(posedge clk) begin
        if (!reset && access_s && op_wr_r) begin
            mem_r[idx_r] <= wdata_r;
        end
    end

endmodule
